// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned SEL_W       = 4;

  localparam logic [SEL_W-1:0] ALL_LANES = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_t;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, load/store port and shared memory bus seen by the arbiter.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [SEL_W-1:0]  mem_sel_i;
  logic              mem_ack_o;
  logic [DATA_W-1:0] mem_rdata_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  logic              err_o;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  bus_ack_i, bus_rdata_i,
    output if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    output err_o, stallreq_if_o, stallreq_mem_o
  );

  // Core + memory side
  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output bus_ack_i, bus_rdata_i,
    input  if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    input  err_o, stallreq_if_o, stallreq_mem_o
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Slave-timeout watchdog: counts BUSY cycles without ack, flags the abort cycle.
module mem_arb_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = timer_width(TIMEOUT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Terminal count is the last waited cycle, so the abort lands exactly TIMEOUT cycles in.
  generate
    if (TIMEOUT == 0) begin : g_no_watchdog
      assign tc_c = 1'b0;
    end else begin : g_watchdog
      assign tc_c = (count_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and load/store ports: MEM priority
// with alternation under contention, one locked transaction at a time, slave watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave arb
);

  arb_state_t state_q, state_d;
  logic       last_mem_q, last_mem_d;
  logic       grant_mem, grant_if;
  logic       busy, timer_clr, timer_en, timeout_tc;

  logic              bus_req_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic [SEL_W-1:0]  bus_sel_d;
  logic              if_ack_d, mem_ack_d, err_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;

  // MEM wins unless it also won last time and IF is waiting.
  assign grant_mem = arb.mem_req_i & ~(last_mem_q & arb.if_req_i);
  assign grant_if  = arb.if_req_i & ~grant_mem;

  assign busy      = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);
  assign timer_clr = ~busy;
  assign timer_en  = busy & ~arb.bus_ack_i;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tc_c (timeout_tc)
  );

  assign arb.stallreq_if_o  = arb.if_req_i & ~arb.if_ack_o;
  assign arb.stallreq_mem_o = arb.mem_req_i & ~arb.mem_ack_o;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_mem_q      <= 1'b0;
      arb.bus_req_o   <= 1'b0;
      arb.bus_we_o    <= 1'b0;
      arb.bus_addr_o  <= '0;
      arb.bus_wdata_o <= '0;
      arb.bus_sel_o   <= '0;
      arb.if_ack_o    <= 1'b0;
      arb.if_rdata_o  <= '0;
      arb.mem_ack_o   <= 1'b0;
      arb.mem_rdata_o <= '0;
      arb.err_o       <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_mem_q      <= last_mem_d;
      arb.bus_req_o   <= bus_req_d;
      arb.bus_we_o    <= bus_we_d;
      arb.bus_addr_o  <= bus_addr_d;
      arb.bus_wdata_o <= bus_wdata_d;
      arb.bus_sel_o   <= bus_sel_d;
      arb.if_ack_o    <= if_ack_d;
      arb.if_rdata_o  <= if_rdata_d;
      arb.mem_ack_o   <= mem_ack_d;
      arb.mem_rdata_o <= mem_rdata_d;
      arb.err_o       <= err_d;
    end
  end

  // Next state; RESP always returns to IDLE so a request seen there is never granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_mem)     state_d = ST_BUSY_MEM;
        else if (grant_if) state_d = ST_BUSY_IF;
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (arb.bus_ack_i || timeout_tc) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    bus_req_d   = arb.bus_req_o;
    bus_we_d    = arb.bus_we_o;
    bus_addr_d  = arb.bus_addr_o;
    bus_wdata_d = arb.bus_wdata_o;
    bus_sel_d   = arb.bus_sel_o;
    if_rdata_d  = arb.if_rdata_o;
    mem_rdata_d = arb.mem_rdata_o;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    last_mem_d  = last_mem_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_mem) begin
          bus_req_d   = 1'b1;
          bus_we_d    = arb.mem_we_i;
          bus_addr_d  = arb.mem_addr_i;
          bus_wdata_d = arb.mem_wdata_i;
          bus_sel_d   = arb.mem_sel_i;
          last_mem_d  = 1'b1;
        end else if (grant_if) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = arb.if_addr_i;
          bus_wdata_d = '0;
          bus_sel_d   = ALL_LANES;
          last_mem_d  = 1'b0;
        end
      end
      ST_BUSY_IF: begin
        if (arb.bus_ack_i) begin
          bus_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = arb.bus_rdata_i;
        end else if (timeout_tc) begin
          bus_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          err_d      = 1'b1;
          if_rdata_d = '0;
        end
      end
      ST_BUSY_MEM: begin
        if (arb.bus_ack_i) begin
          bus_req_d   = 1'b0;
          mem_ack_d   = 1'b1;
          mem_rdata_d = arb.bus_rdata_i;
        end else if (timeout_tc) begin
          bus_req_d   = 1'b0;
          mem_ack_d   = 1'b1;
          err_d       = 1'b1;
          mem_rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, reset sequence, random traffic.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int          N_VEC      = 13;
  localparam int          N_RAND     = 150;

  typedef struct {
    bit          if_req;
    bit          mem_req;
    bit          we;
    logic [31:0] if_addr;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] sdata;
    bit          exp_mem;
    bit          exp_err;
    bit          renew;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;
  bit          served_mem_last;
  vec_t        vecs [N_VEC];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from an IDLE cycle whose requests the caller has just driven.
  // The slave acks after `waits` BUSY cycles; exp_err means it never acks in time.
  task automatic do_txn(input string tag, input bit exp_mem, input int waits,
                        input logic [31:0] sdata, input bit exp_err, input bit renew);
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_we;
    logic [3:0]  e_sel;
    int          last_k;
    last_k = exp_err ? int'(TB_TIMEOUT) - 1 : waits;
    if (exp_mem) begin
      e_addr = ifc.mem_addr_i; e_wdata = ifc.mem_wdata_i; e_we = ifc.mem_we_i; e_sel = ifc.mem_sel_i;
    end else begin
      e_addr = ifc.if_addr_i; e_wdata = 32'h0; e_we = 1'b0; e_sel = 4'hF;
    end

    @(negedge clk);
    chk1({tag, " idle bus_req"}, ifc.bus_req_o, 1'b0);
    chk1({tag, " idle if_ack"}, ifc.if_ack_o, 1'b0);
    chk1({tag, " idle mem_ack"}, ifc.mem_ack_o, 1'b0);
    chk1({tag, " idle stallreq_if"}, ifc.stallreq_if_o, ifc.if_req_i);
    chk1({tag, " idle stallreq_mem"}, ifc.stallreq_mem_o, ifc.mem_req_i);

    for (int k = 0; k <= last_k; k++) begin
      tick();
      ifc.bus_ack_i   = (k == waits);
      ifc.bus_rdata_i = (k == waits) ? sdata : $urandom();
      // Granted master's payload is scrambled: the bus must keep the latched copy
      if (exp_mem) begin
        ifc.mem_addr_i  = $urandom();
        ifc.mem_wdata_i = $urandom();
        ifc.mem_sel_i   = 4'($urandom());
        ifc.mem_we_i    = 1'($urandom());
      end else begin
        ifc.if_addr_i = $urandom();
      end
      @(negedge clk);
      chk1({tag, " busy bus_req"}, ifc.bus_req_o, 1'b1);
      chk32({tag, " busy bus_addr"}, ifc.bus_addr_o, e_addr);
      chk32({tag, " busy bus_wdata"}, ifc.bus_wdata_o, e_wdata);
      chk1({tag, " busy bus_we"}, ifc.bus_we_o, e_we);
      chk32({tag, " busy bus_sel"}, 32'(ifc.bus_sel_o), 32'(e_sel));
      chk1({tag, " busy if_ack"}, ifc.if_ack_o, 1'b0);
      chk1({tag, " busy mem_ack"}, ifc.mem_ack_o, 1'b0);
      chk1({tag, " busy err"}, ifc.err_o, 1'b0);
      chk1({tag, " busy stallreq_if"}, ifc.stallreq_if_o, ifc.if_req_i);
      chk1({tag, " busy stallreq_mem"}, ifc.stallreq_mem_o, ifc.mem_req_i);
    end

    tick();
    ifc.bus_ack_i   = 1'b0;
    ifc.bus_rdata_i = $urandom();
    e_rdata = exp_err ? 32'h0 : sdata;
    @(negedge clk);
    chk1({tag, " resp bus_req"}, ifc.bus_req_o, 1'b0);
    chk1({tag, " resp err"}, ifc.err_o, exp_err);
    if (exp_mem) begin
      chk1({tag, " resp mem_ack"}, ifc.mem_ack_o, 1'b1);
      chk1({tag, " resp if_ack"}, ifc.if_ack_o, 1'b0);
      chk32({tag, " resp mem_rdata"}, ifc.mem_rdata_o, e_rdata);
      chk32({tag, " resp if_rdata hold"}, ifc.if_rdata_o, exp_if_rdata);
      chk1({tag, " resp stallreq_mem"}, ifc.stallreq_mem_o, 1'b0);
      exp_mem_rdata = e_rdata;
      if (!renew) ifc.mem_req_i = 1'b0;
    end else begin
      chk1({tag, " resp if_ack"}, ifc.if_ack_o, 1'b1);
      chk1({tag, " resp mem_ack"}, ifc.mem_ack_o, 1'b0);
      chk32({tag, " resp if_rdata"}, ifc.if_rdata_o, e_rdata);
      chk32({tag, " resp mem_rdata hold"}, ifc.mem_rdata_o, exp_mem_rdata);
      chk1({tag, " resp stallreq_if"}, ifc.stallreq_if_o, 1'b0);
      exp_if_rdata = e_rdata;
      if (!renew) ifc.if_req_i = 1'b0;
    end
    served_mem_last = exp_mem;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    bit exp_mem_r, exp_err_r, renew_r;
    int waits_r;
    n_chk = 0; n_fail = 0;
    exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0; served_mem_last = 1'b0;
    rst = 1'b1;
    ifc.if_req_i = 1'b0; ifc.if_addr_i = 32'h0;
    ifc.mem_req_i = 1'b0; ifc.mem_we_i = 1'b0; ifc.mem_addr_i = 32'h0;
    ifc.mem_wdata_i = 32'h0; ifc.mem_sel_i = 4'h0;
    ifc.bus_ack_i = 1'b0; ifc.bus_rdata_i = 32'h0;

    //              if mem we if_addr       mem_addr      wdata         sel    w  sdata         M  err rnw
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        4'h0, 0, 32'h00000013, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'hDEADBEEF, 4'h3, 0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'hDEADBEEF, 4'h3, 0, 32'h00000093, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'hDEADBEEF, 4'h3, 1, 32'h0000A5A5, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,   32'h0,        4'h0, 2, 32'h00400093, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 32'h0,        4'hF, 3, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0,   32'h0,        4'h0, 9, 32'h00001111, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h304, 32'h0,        4'hF, 5, 32'h00002222, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h308, 32'h0BADF00D, 4'hC, 0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h30C, 32'h0,        4'hF, 1, 32'h00000033, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h30C, 32'h0,        4'hF, 2, 32'h00000044, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h110, 32'h0,   32'h0,        4'h0, 0, 32'h00000055, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h114, 32'h0,   32'h0,        4'h0, 0, 32'h00000066, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset bus_req", ifc.bus_req_o, 1'b0);
    chk1("reset bus_we", ifc.bus_we_o, 1'b0);
    chk32("reset bus_addr", ifc.bus_addr_o, 32'h0);
    chk32("reset bus_wdata", ifc.bus_wdata_o, 32'h0);
    chk32("reset bus_sel", 32'(ifc.bus_sel_o), 32'h0);
    chk1("reset if_ack", ifc.if_ack_o, 1'b0);
    chk1("reset mem_ack", ifc.mem_ack_o, 1'b0);
    chk32("reset if_rdata", ifc.if_rdata_o, 32'h0);
    chk32("reset mem_rdata", ifc.mem_rdata_o, 32'h0);
    chk1("reset err", ifc.err_o, 1'b0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      tick();
      ifc.if_req_i    = vecs[i].if_req;
      ifc.if_addr_i   = vecs[i].if_addr;
      ifc.mem_req_i   = vecs[i].mem_req;
      ifc.mem_we_i    = vecs[i].we;
      ifc.mem_addr_i  = vecs[i].mem_addr;
      ifc.mem_wdata_i = vecs[i].wdata;
      ifc.mem_sel_i   = vecs[i].sel;
      do_txn($sformatf("vec%0d", i), vecs[i].exp_mem, vecs[i].waits, vecs[i].sdata,
             vecs[i].exp_err, vecs[i].renew);
    end

    // Reset in the middle of a locked load/store: bus drops at once and no ack follows
    tick();
    ifc.if_req_i = 1'b0;
    ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'b1; ifc.mem_addr_i = 32'h400;
    ifc.mem_wdata_i = 32'h12345678; ifc.mem_sel_i = 4'hF;
    ifc.bus_ack_i = 1'b0;
    tick();
    @(negedge clk);
    chk1("rstmid busy bus_req", ifc.bus_req_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("rstmid async bus_req", ifc.bus_req_o, 1'b0);
    chk32("rstmid async bus_addr", ifc.bus_addr_o, 32'h0);
    chk1("rstmid async mem_ack", ifc.mem_ack_o, 1'b0);
    tick();
    ifc.bus_ack_i = 1'b1; ifc.bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk1("rstmid held mem_ack", ifc.mem_ack_o, 1'b0);
    chk32("rstmid held mem_rdata", ifc.mem_rdata_o, 32'h0);
    tick();
    rst = 1'b0; ifc.bus_ack_i = 1'b0; ifc.mem_req_i = 1'b0;
    @(negedge clk);
    chk1("rstmid after mem_ack", ifc.mem_ack_o, 1'b0);
    chk1("rstmid after bus_req", ifc.bus_req_o, 1'b0);
    served_mem_last = 1'b0; exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;
    tick();
    ifc.if_req_i = 1'b1; ifc.if_addr_i = 32'h500;
    do_txn("rstmid fetch", 1'b0, 0, 32'h55AA55AA, 1'b0, 1'b0);

    // Random traffic: masters hold requests until acked; grant follows the alternation rule
    for (int t = 0; t < N_RAND; t++) begin
      tick();
      if (!ifc.if_req_i && $urandom_range(1, 0) == 1) begin
        ifc.if_req_i = 1'b1; ifc.if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!ifc.mem_req_i && $urandom_range(1, 0) == 1) begin
        ifc.mem_req_i = 1'b1; ifc.mem_we_i = 1'($urandom()); ifc.mem_addr_i = $urandom();
        ifc.mem_wdata_i = $urandom(); ifc.mem_sel_i = 4'($urandom());
      end
      if (!ifc.if_req_i && !ifc.mem_req_i) begin
        ifc.if_req_i = 1'b1; ifc.if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (ifc.if_req_i && ifc.mem_req_i) exp_mem_r = !served_mem_last;
      else                               exp_mem_r = ifc.mem_req_i;
      waits_r   = $urandom_range(5, 0);
      exp_err_r = (waits_r >= int'(TB_TIMEOUT));
      renew_r   = ($urandom_range(3, 0) == 0);
      do_txn($sformatf("rand%0d", t), exp_mem_r, waits_r, $urandom(), exp_err_r, renew_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
